// File: rtl/fst_mon_pkg.sv
// Shared types for the fst run monitor: FSM state encoding and verdict helper.
// Pure declarations; no logic, no latency, no flow control.
package fst_mon_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RUN     = 3'd1,
        HALTED  = 3'd2,
        STALLED = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_t;

    function automatic logic is_verdict(input mon_state_t s);
        return (s == HALTED) || (s == STALLED) || (s == TIMEOUT);
    endfunction

endpackage

// File: rtl/fst_mon_trace_buf.sv
// PC trace ring buffer: synchronous write, combinational read of entry rd_idx back from newest.
// One-cycle write latency; never stalls, writes simply stop when wr_en drops.
module fst_mon_trace_buf #(
    parameter int PC_WIDTH = 8,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [PC_WIDTH-1:0]      wr_pc,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [PC_WIDTH-1:0]      rd_pc
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // Contents survive reset so the last run stays readable after a restart.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= wr_pc;
        end
    end

    assign rd_pc = mem[wr_ptr - AW'(1) - rd_idx];

endmodule

// File: rtl/fst_run_monitor.sv
// Run-control/watchdog for the fst core: holds core reset, then flags halt, PC stall or timeout; 1-cycle latency.
// No backpressure; optional PC trace under FST_MON_TRACE_EN.
module fst_run_monitor
    import fst_mon_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int RESET_HOLD  = 3,
    parameter int STALL_LIMIT = 16,
    parameter int TIMEOUT     = 1000000,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 halting,
    input  logic [PC_WIDTH-1:0]  pc_in,
    output logic                 core_reset_n,
    output mon_state_t           state,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycles
`ifdef FST_MON_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_WIDTH-1:0]            trace_pc
`endif
);

    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [HW-1:0]        HOLD_LAST  = HW'(RESET_HOLD - 1);
    localparam logic [SW-1:0]        STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT - 1);

    logic [HW-1:0]       hold_cnt;
    logic [SW-1:0]       stall_cnt;
    logic [PC_WIDTH-1:0] last_pc;
    logic                pc_eq;

    // cycles is zero only on the first RUN cycle, where last_pc is not yet valid.
    assign pc_eq = (cycles != '0) && (pc_in == last_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HOLD;
            core_reset_n <= 1'b0;
            done         <= 1'b0;
            cycles       <= '0;
            hold_cnt     <= '0;
            stall_cnt    <= '0;
            last_pc      <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end else begin
                        state        <= RUN;
                        core_reset_n <= 1'b1;
                    end
                end
                RUN: begin
                    last_pc <= pc_in;
                    if (halting) begin
                        state <= HALTED;
                        done  <= 1'b1;
                    end else begin
                        if (cycles != '1) begin
                            cycles <= cycles + CNT_WIDTH'(1);
                        end
                        stall_cnt <= pc_eq ? stall_cnt + SW'(1) : '0;
                        if (pc_eq && stall_cnt == STALL_LAST) begin
                            state <= STALLED;
                            done  <= 1'b1;
                        end else if (cycles == TO_LAST) begin
                            state <= fst_mon_pkg::TIMEOUT;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FST_MON_TRACE_EN
    logic trace_wr;

    // The halting cycle is not a counted run cycle, so it is not recorded either.
    assign trace_wr = (state == RUN) && !halting;

    fst_mon_trace_buf #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (TRACE_DEPTH)
    ) u_trace (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (trace_wr),
        .wr_pc  (pc_in),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc)
    );
`endif

endmodule

// File: tb/tb_fst_run_monitor.sv
// Randomized and directed bench for fst_run_monitor against a sample-history reference model.
module tb_fst_run_monitor;
    import fst_mon_pkg::*;

    localparam int P_HOLD  = 3;
    localparam int P_STALL = 16;
    localparam int P_TO    = 100;
    localparam int P_DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        halting;
    logic [7:0]  pc_in;
    logic        core_reset_n;
    mon_state_t  state;
    logic        done;
    logic [31:0] cycles;
`ifdef FST_MON_TRACE_EN
    logic [2:0]  trace_idx;
    logic [7:0]  trace_pc;
`endif

    fst_run_monitor #(
        .PC_WIDTH    (8),
        .CNT_WIDTH   (32),
        .RESET_HOLD  (P_HOLD),
        .STALL_LIMIT (P_STALL),
        .TIMEOUT     (P_TO),
        .TRACE_DEPTH (P_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .halting      (halting),
        .pc_in        (pc_in),
        .core_reset_n (core_reset_n),
        .state        (state),
        .done         (done),
        .cycles       (cycles)
`ifdef FST_MON_TRACE_EN
        ,
        .trace_idx    (trace_idx),
        .trace_pc     (trace_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the list of counted PC samples since RUN entry.
    mon_state_t m_state;
    int         m_cycles;
    logic [7:0] m_hist[$];

    function automatic int trailing_run();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != m_hist[m_hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit m_done();
        return (m_state == HALTED) || (m_state == STALLED) || (m_state == TIMEOUT);
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".state"}, longint'(state), longint'(m_state));
        check_eq({tag, ".cycles"}, longint'(cycles), longint'(m_cycles));
        check_eq({tag, ".done"}, longint'(done), longint'(m_done()));
        check_eq({tag, ".core_reset_n"}, longint'(core_reset_n), longint'(m_state != HOLD));
    endtask

    // kind: 0 incrementing pc + halt at halt_at, 1 stall with glitch, 2 pc always changing,
    //       3 stuck pc with halt on the stall-limit cycle, 4 random
    task automatic run_episode(input int kind, input int halt_at, input int rst_at, input int stick);
        logic [7:0] pc;
        logic [7:0] prev;
        bit         h;
        reset   = 1'b1;
        halting = 1'b0;
        pc_in   = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_state  = HOLD;
        m_cycles = 0;
        m_hist.delete();
        @(negedge clk);
        check_outputs("reset");
        for (int i = 1; i <= P_HOLD; i++) begin
            @(posedge clk);
            #1;
            if (i == P_HOLD) m_state = RUN;
            check_outputs("hold");
        end
        prev = 8'h00;
        for (int k = 0; k < P_TO + 2 && m_state == RUN; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                m_state  = HOLD;
                m_cycles = 0;
                m_hist.delete();
                check_outputs("mid_reset");
                return;
            end
            case (kind)
                1:       begin pc = (k < 10) ? 8'(k) : (k == 25 ? 8'h34 : 8'h12); h = 1'b0; end
                2:       begin pc = 8'(k); h = 1'b0; end
                3:       begin pc = 8'h55; h = (k == P_STALL); end
                4:       begin
                             pc = ($urandom_range(0, 99) < stick) ? prev : 8'($urandom);
                             h  = ($urandom_range(0, 149) == 0);
                         end
                default: begin pc = 8'(k); h = (k == halt_at); end
            endcase
            pc_in   = pc;
            halting = h;
            @(posedge clk);
            #1;
            if (h) begin
                m_state = HALTED;
            end else begin
                m_hist.push_back(pc);
                m_cycles++;
                if (trailing_run() >= P_STALL + 1) m_state = STALLED;
                else if (m_cycles == P_TO)          m_state = TIMEOUT;
            end
            check_outputs("run");
            prev = pc;
        end
        check_eq("verdict_reached", longint'(m_done()), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pc_in   = 8'($urandom);
            halting = 1'($urandom);
            @(posedge clk);
            #1;
            check_outputs("frozen");
        end
`ifdef FST_MON_TRACE_EN
        @(negedge clk);
        for (int i = 0; i < P_DEPTH && i < m_hist.size(); i++) begin
            trace_idx = 3'(i);
            #1;
            check_eq("trace_pc", longint'(trace_pc), longint'(m_hist[m_hist.size() - 1 - i]));
        end
`endif
    endtask

    initial begin
        reset   = 1'b1;
        halting = 1'b0;
        pc_in   = 8'h00;
`ifdef FST_MON_TRACE_EN
        trace_idx = 3'd0;
`endif
        run_episode(0, 40, -1, 0);
        run_episode(1, -1, -1, 0);
        run_episode(2, -1, -1, 0);
        run_episode(3, -1, -1, 0);
        run_episode(2, -1, 20, 0);
        run_episode(0, 20, -1, 0);
        run_episode(0, 0, -1, 0);
        for (int e = 0; e < 30; e++) begin
            int stick;
            int rst_at;
            case ($urandom_range(0, 2))
                0:       stick = 50;
                1:       stick = 90;
                default: stick = 97;
            endcase
            rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : -1;
            run_episode(4, -1, rst_at, stick);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected $finish before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
